// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: mode encodings shared by the universal shift register and its bench
package univ_shift_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;
endpackage

// File: rtl/shift_cnt.sv
// shift_cnt: saturating shift counter with a registered done pulse on reaching WIDTH
module shift_cnt #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          shift,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          done
);
  localparam logic [CW-1:0] MAX = CW'(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  // done fires only on the WIDTH-1 -> WIDTH step, so saturated shifts stay silent
  always_comb begin
    cnt_d  = clear ? '0 : (shift && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    done_d = shift && cnt_q == MAX - 1'b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign cnt  = cnt_q;
  assign full = cnt_q == MAX;
  assign done = done_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register (hold / shift right / shift left / load)
// with a registered serial output and a saturating shifts-since-load counter
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pdin,
  output logic [WIDTH-1:0]           pdout,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       done
);
  logic [WIDTH-1:0] pdout_q, pdout_d;
  logic             sout_q, sout_d;
  logic             shr, shl, ld;
  always_comb begin
    shr     = en && mode == MODE_SHR;
    shl     = en && mode == MODE_SHL;
    ld      = en && mode == MODE_LOAD;
    pdout_d = ld  ? pdin :
              shr ? {sin_r, pdout_q[WIDTH-1:1]} :
              shl ? {pdout_q[WIDTH-2:0], sin_l} : pdout_q;
    sout_d  = shr ? pdout_q[0] : shl ? pdout_q[WIDTH-1] : sout_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pdout_q <= RST_VAL;
      sout_q  <= 1'b0;
    end else begin
      pdout_q <= pdout_d;
      sout_q  <= sout_d;
    end
  end
  shift_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .shift(shr || shl),
    .clear(ld),
    .cnt  (cnt),
    .full (full),
    .done (done)
  );
  assign pdout = pdout_q;
  assign sout  = sout_q;
endmodule
